// File: rtl/jump_charge_ctl.sv
// jump_charge_ctl: character action sequencer for the Jump King core.
// Turns held key levels into walk enables and a charged jump request, hands
// the jump to physics over a req/ack handshake and tracks ground contact.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_tick          one-cycle pulse per video frame (charge time base)
//   key_space/left/right key levels from the keyboard decoder
//   on_ground           character is standing on a platform
//   jump_ack            physics accepted the pending jump
//   walk_left/right     horizontal walk enables
//   charging            jump charge in progress
//   jump_req            launch pending (held until jump_ack)
//   jump_power          launch strength, max(charge, CHARGE_MIN)
//   jump_dir            00 vertical, 01 left, 10 right
//   state               FSM encoding for debug/overlay
module jump_charge_ctl #(
  parameter int CHARGE_W   = 6,
  parameter int CHARGE_MAX = 60,
  parameter int CHARGE_MIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                key_space,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                on_ground,
  input  logic                jump_ack,
  output logic                walk_left,
  output logic                walk_right,
  output logic                charging,
  output logic                jump_req,
  output logic [CHARGE_W-1:0] jump_power,
  output logic [1:0]          jump_dir,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WALK     = 3'd1,
    CHARGE   = 3'd2,
    LAUNCH   = 3'd3,
    AIRBORNE = 3'd4
  } state_t;

  localparam logic [CHARGE_W-1:0] MAXV = CHARGE_W'(CHARGE_MAX);
  localparam logic [CHARGE_W-1:0] MINV = CHARGE_W'(CHARGE_MIN);

  state_t              cur, nxt;
  logic                armed;
  logic [CHARGE_W-1:0] cnt;
  logic [1:0]          key_dir;
  logic                one_key;
  logic                launch_go;

  assign state = cur;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    nxt     = cur;
    one_key = key_left ^ key_right;
    key_dir = 2'b00;
    if (key_left && !key_right) key_dir = 2'b01;
    if (key_right && !key_left) key_dir = 2'b10;
    case (cur)
      IDLE, WALK: begin
        if (!on_ground)               nxt = AIRBORNE;
        else if (key_space && armed)  nxt = CHARGE;
        else if (one_key)             nxt = WALK;
        else                          nxt = IDLE;
      end
      CHARGE: begin
        // ground loss outranks release: no request when both happen together
        if (!on_ground)      nxt = AIRBORNE;
        else if (!key_space) nxt = LAUNCH;
      end
      LAUNCH:   if (jump_ack)  nxt = AIRBORNE;
      AIRBORNE: if (on_ground) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  assign launch_go = (cur == CHARGE) && (nxt == LAUNCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // ---------------------------------------------------------------------
  // Re-arm: space must be seen low after each launch before a new charge.
  // Launch entry wins over the release seen in that same cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             armed <= 1'b1;
    else if (launch_go)  armed <= 1'b0;
    else if (!key_space) armed <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Charge counter: cleared on entry (entry-cycle tick ignored), counts
  // only ticks while staying in CHARGE (release-cycle tick ignored).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (cur != CHARGE && nxt == CHARGE) cnt <= '0;
    else if (cur == CHARGE && nxt == CHARGE && frame_tick && cnt < MAXV)
      cnt <= cnt + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Registered outputs decoded from the next state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walk_left  <= 1'b0;
      walk_right <= 1'b0;
      charging   <= 1'b0;
      jump_req   <= 1'b0;
      jump_power <= '0;
      jump_dir   <= 2'b00;
    end else begin
      walk_left  <= (nxt == WALK) && key_left && !key_right;
      walk_right <= (nxt == WALK) && key_right && !key_left;
      charging   <= (nxt == CHARGE);
      jump_req   <= (nxt == LAUNCH);
      // direction follows keys while charging and is latched with the power
      // at launch; both then hold until the next charge
      if (nxt == CHARGE || launch_go) jump_dir <= key_dir;
      if (launch_go) jump_power <= (cnt < MINV) ? MINV : cnt;
    end
  end

endmodule

// File: tb/tb_jump_charge_ctl.sv
module tb_jump_charge_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, key_space, key_left, key_right, on_ground, jump_ack;
  logic       walk_left, walk_right, charging, jump_req;
  logic [5:0] jump_power;
  logic [1:0] jump_dir;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0] pwr;
    logic [1:0] dir;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  jump_charge_ctl #(.CHARGE_W(6), .CHARGE_MAX(60), .CHARGE_MIN(4)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_space(key_space),
    .key_left(key_left), .key_right(key_right), .on_ground(on_ground),
    .jump_ack(jump_ack), .walk_left(walk_left), .walk_right(walk_right),
    .charging(charging), .jump_req(jump_req), .jump_power(jump_power),
    .jump_dir(jump_dir), .state(state)
  );

  // Scoreboard: every rising jump_req pops the expected launch parameters.
  always @(negedge clk) begin
    if (!rst && jump_req && !req_q) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_req got power=%0d dir=%b, expected no request", jump_power, jump_dir);
      end else begin
        e = sb.pop_front();
        if (jump_power !== e.pwr || jump_dir !== e.dir) begin
          fails++;
          $display("FAIL sb_launch got power=%0d dir=%b, expected power=%0d dir=%b",
                   jump_power, jump_dir, e.pwr, e.dir);
        end
      end
    end
    req_q <= jump_req;
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; cycle(1);
      frame_tick = 1'b0; cycle(1);
    end
  endtask

  task automatic ack_jump();
    jump_ack = 1'b1; cycle(1);
    jump_ack = 1'b0;
  endtask

  task automatic land();
    on_ground = 1'b1; key_space = 1'b0; key_left = 1'b0; key_right = 1'b0;
    cycle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 0; key_space = 0; key_left = 0; key_right = 0;
    on_ground = 1'b1; jump_ack = 0;
    cycle(2);
    tests++;
    if ({walk_left, walk_right, charging, jump_req} !== 4'b0 || state !== 3'd0 ||
        jump_power !== 6'd0 || jump_dir !== 2'b00) begin
      fails++;
      $display("FAIL reset_state got st=%0d wl=%b wr=%b ch=%b req=%b pw=%0d dir=%b, expected all zero",
               state, walk_left, walk_right, charging, jump_req, jump_power, jump_dir);
    end
    rst = 1'b0;
    cycle(1);
  endtask

  task automatic test_short_tap();
    key_right = 1'b1; key_space = 1'b1;
    cycle(1);
    tests++;
    if (charging !== 1'b1 || state !== 3'd2 || jump_dir !== 2'b10 || walk_right !== 1'b0) begin
      fails++;
      $display("FAIL tap_charge got ch=%b st=%0d dir=%b wr=%b, expected ch=1 st=2 dir=10 wr=0",
               charging, state, jump_dir, walk_right);
    end
    pulse_ticks(2);
    sb.push_back('{pwr: 6'd4, dir: 2'b10});
    key_space = 1'b0;
    cycle(1);
    tests++;
    if (jump_req !== 1'b1 || state !== 3'd3 || charging !== 1'b0) begin
      fails++;
      $display("FAIL tap_req_latency got req=%b st=%0d ch=%b, expected req=1 st=3 ch=0", jump_req, state, charging);
    end
    key_right = 1'b0;           // ignored in LAUNCH
    cycle(2);
    tests++;
    if (jump_req !== 1'b1 || jump_dir !== 2'b10) begin
      fails++;
      $display("FAIL tap_hold got req=%b dir=%b, expected req=1 dir=10", jump_req, jump_dir);
    end
    jump_ack = 1'b1; cycle(1); jump_ack = 1'b0;
    tests++;
    if (state !== 3'd4 || jump_req !== 1'b0 || jump_power !== 6'd4) begin
      fails++;
      $display("FAIL tap_ack got st=%0d req=%b pw=%0d, expected st=4 req=0 pw=4", state, jump_req, jump_power);
    end
    land();
  endtask

  task automatic test_saturation();
    key_space = 1'b1;
    cycle(1);
    pulse_ticks(100);
    sb.push_back('{pwr: 6'd60, dir: 2'b00});
    key_space = 1'b0;
    cycle(1);
    tests++;
    if (jump_req !== 1'b1 || jump_power !== 6'd60 || jump_dir !== 2'b00) begin
      fails++;
      $display("FAIL sat_launch got req=%b pw=%0d dir=%b, expected req=1 pw=60 dir=00", jump_req, jump_power, jump_dir);
    end
    ack_jump();
    land();
  endtask

  task automatic test_rearm();
    key_space = 1'b1;
    cycle(1);
    pulse_ticks(1);
    sb.push_back('{pwr: 6'd4, dir: 2'b00});
    key_space = 1'b0;
    cycle(1);
    key_space = 1'b1;           // re-pressed during LAUNCH and held to landing
    cycle(1);
    on_ground = 1'b0;
    ack_jump();
    cycle(2);
    on_ground = 1'b1;
    cycle(1);
    tests++;
    if (state !== 3'd0 || charging !== 1'b0) begin
      fails++;
      $display("FAIL rearm_land got st=%0d ch=%b, expected st=0 ch=0", state, charging);
    end
    cycle(3);
    tests++;
    if (state !== 3'd0 || charging !== 1'b0) begin
      fails++;
      $display("FAIL rearm_stay got st=%0d ch=%b, expected st=0 ch=0", state, charging);
    end
    key_space = 1'b0; cycle(1);
    key_space = 1'b1; cycle(1);
    tests++;
    if (charging !== 1'b1 || state !== 3'd2) begin
      fails++;
      $display("FAIL rearm_charge got ch=%b st=%0d, expected ch=1 st=2", charging, state);
    end
    sb.push_back('{pwr: 6'd4, dir: 2'b00});
    key_space = 1'b0;
    cycle(1);
    ack_jump();
    land();
  endtask

  task automatic test_ground_loss();
    key_space = 1'b1;
    cycle(1);
    pulse_ticks(10);
    on_ground = 1'b0; key_space = 1'b0;   // loss and release together
    cycle(1);
    tests++;
    if (state !== 3'd4 || charging !== 1'b0 || jump_req !== 1'b0) begin
      fails++;
      $display("FAIL gloss_air got st=%0d ch=%b req=%b, expected st=4 ch=0 req=0", state, charging, jump_req);
    end
    cycle(3);
    tests++;
    if (jump_req !== 1'b0 || state !== 3'd4) begin
      fails++;
      $display("FAIL gloss_noreq got req=%b st=%0d, expected req=0 st=4", jump_req, state);
    end
    on_ground = 1'b1;
    cycle(1);
    tests++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL gloss_land got st=%0d, expected st=0", state);
    end
  endtask

  task automatic test_walk();
    key_left = 1'b1;
    cycle(1);
    tests++;
    if (walk_left !== 1'b1 || walk_right !== 1'b0 || state !== 3'd1) begin
      fails++;
      $display("FAIL walk_left got wl=%b wr=%b st=%0d, expected wl=1 wr=0 st=1", walk_left, walk_right, state);
    end
    key_right = 1'b1;
    cycle(1);
    tests++;
    if (walk_left !== 1'b0 || walk_right !== 1'b0 || state !== 3'd0) begin
      fails++;
      $display("FAIL walk_both got wl=%b wr=%b st=%0d, expected wl=0 wr=0 st=0", walk_left, walk_right, state);
    end
    key_left = 1'b0; key_right = 1'b0;
    cycle(1);
    // ticks on the entry cycle and on the release cycle must not count
    for (int k = 0; k < 2; k++) begin
      key_space = 1'b1; frame_tick = 1'b1;
      cycle(1);
      frame_tick = 1'b0;
      pulse_ticks(k == 0 ? 3 : 6);
      sb.push_back('{pwr: (k == 0 ? 6'd4 : 6'd6), dir: 2'b00});
      key_space = 1'b0; frame_tick = 1'b1;
      cycle(1);
      frame_tick = 1'b0;
      tests++;
      if (jump_req !== 1'b1 || jump_power !== (k == 0 ? 6'd4 : 6'd6)) begin
        fails++;
        $display("FAIL walk_coinc_%0d got req=%b pw=%0d, expected req=1 pw=%0d",
                 k, jump_req, jump_power, (k == 0 ? 4 : 6));
      end
      ack_jump();
      land();
    end
  endtask

  task automatic test_reset_mid_launch();
    key_space = 1'b1;
    cycle(1);
    pulse_ticks(2);
    sb.push_back('{pwr: 6'd4, dir: 2'b00});
    key_space = 1'b0;
    cycle(1);
    #5;                         // past the monitor's negedge sample
    rst = 1'b1;
    #1;
    tests++;
    if ({walk_left, walk_right, charging, jump_req} !== 4'b0 || state !== 3'd0 || jump_power !== 6'd0) begin
      fails++;
      $display("FAIL rst_mid_launch got st=%0d req=%b ch=%b pw=%0d, expected st=0 req=0 ch=0 pw=0",
               state, jump_req, charging, jump_power);
    end
    cycle(1);
    rst = 1'b0;
    cycle(2);
    tests++;
    if (state !== 3'd0 || jump_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart got st=%0d req=%b, expected st=0 req=0", state, jump_req);
    end
  endtask

  initial begin
    test_reset();
    test_short_tap();
    test_saturation();
    test_rearm();
    test_ground_loss();
    test_walk();
    test_reset_mid_launch();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got %0d pending launches, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jump_charge_ctl.md
# jump_charge_ctl

Character action sequencer for the Jump King core. It sits between the keyboard key decoder (level outputs `key_space`, `key_left`, `key_right`) and the character physics block. It converts held-key levels into walk enables and a charged-jump request with a strength and direction. The request is delivered to physics over a req/ack handshake, and the block tracks ground contact to decide when a new charge is allowed.

## Interface
- `CHARGE_W`, default 6: width of the charge counter and `jump_power`.
- `CHARGE_MAX`, default 60: saturation value of the charge counter, in frame ticks.
- `CHARGE_MIN`, default 4: minimum `jump_power` issued for any jump.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-`clk` pulse per video frame.
- `key_space`, `key_left`, `key_right` in 1 each: key levels from the keyboard decoder.
- `on_ground` in 1: character standing on a platform (from physics).
- `jump_ack` in 1: physics accepted the jump (handshake).
- `walk_left`, `walk_right` out 1 each: horizontal walk enables.
- `charging` out 1: a jump charge is in progress.
- `jump_req` out 1: a launch is pending.
- `jump_power` out `CHARGE_W`: launch strength.
- `jump_dir` out 2: launch direction; 00 vertical, 01 left, 10 right, 11 never driven.
- `state` out 3: FSM encoding, for debug and overlay.

## Operation
- FSM states and encodings: IDLE=0, WALK=1, CHARGE=2, LAUNCH=3, AIRBORNE=4.
- `armed` flag:
  - set in any cycle with `key_space`=0;
  - cleared on entry to LAUNCH;
  - CHARGE may be entered only when `armed`=1, so space must be released and re-pressed after every jump.
- IDLE transitions, in priority order:
  - `!on_ground` → AIRBORNE;
  - `key_space && armed` → CHARGE, counter cleared to 0;
  - exactly one of left/right → WALK;
  - otherwise stay.
- WALK:
  - `walk_left`/`walk_right` follow the single pressed key;
  - `!on_ground` → AIRBORNE;
  - `key_space && armed` → CHARGE;
  - neither key or both keys → IDLE.
- CHARGE:
  - counter +1 on each `frame_tick`, saturating at `CHARGE_MAX`;
  - `jump_dir` tracks keys every cycle: left only → 01, right only → 10, none or both → 00;
  - `!on_ground` → AIRBORNE; counter discarded, no request;
  - `key_space`=0 → LAUNCH, `jump_power` = max(counter, `CHARGE_MIN`).
- LAUNCH:
  - `jump_req`=1; `jump_power` and `jump_dir` frozen;
  - key changes are ignored;
  - `jump_ack`=1 → AIRBORNE.
  - There is no timeout.
- AIRBORNE:
  - walk enables, `charging` and `jump_req` are 0;
  - `on_ground`=1 → IDLE.
- `jump_ack` outside LAUNCH is ignored.
- Arithmetic: the counter never wraps. `CHARGE_MAX` < 2^`CHARGE_W` and `CHARGE_MIN` ≤ `CHARGE_MAX` are required.

## Timing
- All outputs are registered, decoded from the next state, so they change together with `state`.
- Reset values:
  - state IDLE;
  - all 1-bit outputs 0;
  - `jump_power` 0, `jump_dir` 00, counter 0;
  - `armed` 1.
- Key-to-output latency is 1 cycle:
  - space sampled high at cycle N → `charging`=1 at N+1;
  - left sampled at N in IDLE → `walk_left`=1 at N+1.
- Space sampled low at M in CHARGE → `jump_req`=1 at M+1, with power and direction valid in the same cycle.
- `jump_ack` sampled high at K → `jump_req`=0 at K+1.
  - `jump_power` and `jump_dir` hold their values until the next CHARGE entry.
- `frame_tick` in the same cycle as the space release is not counted.
- `frame_tick` in the CHARGE entry cycle (the IDLE/WALK cycle where space is sampled) is not counted.
- Ground loss and space release in the same cycle: ground loss wins → AIRBORNE, no request.
- Reset mid-operation (including mid-LAUNCH) drops all outputs asynchronously; the FSM restarts in IDLE.

## Test plan
- Power-on/reset: assert `rst` mid-LAUNCH → `jump_req`, `charging`, walk enables go 0 immediately; `state`=0; `jump_power`=0.
- Short tap:
  - stimulus: `on_ground`=1, `key_right` held, space held across 2 `frame_tick`s then released;
  - response: `jump_req`=1 one cycle after release, `jump_power`=4, `jump_dir`=10;
  - then `jump_ack` pulse → state 4 next cycle, `jump_req`=0.
- Saturation: space held for 100 frame ticks with no direction key, then released → `jump_power`=60, `jump_dir`=00.
- Re-arm:
  - stimulus: land (`on_ground` 0→1) with space still held;
  - response: state 0 and stays 0, no `charging`;
  - space low 1 cycle then high → `charging`=1 one cycle later.
- Ground loss: drop `on_ground` after 10 ticks of charge → state 4, `jump_req` never asserts, `charging`=0.
- Walk:
  - left alone → `walk_left`=1 after 1 cycle;
  - add right → state 0, both enables 0;
  - `frame_tick` coincident with space release → power excludes that tick (3 ticks held → power 4 via min, 6 ticks → 6).
